// File: rtl/axi_mem_arbiter2_if.sv
// One AXI-style port (4-bit IDs, 4-bit burst length) with the AW, W, B, AR and R channels.
// The master modport is what a bus master drives; the slave modport is the memory's view.
interface axi_mem_arbiter2_if #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                     awvalid;
   logic                     awready;
   logic [3:0]               awid;
   logic [ADDRESS_WIDTH-1:0] awaddr;
   logic [3:0]               awlen;
   logic [2:0]               awsize;
   logic [1:0]               awburst;

   logic                     wvalid;
   logic                     wready;
   logic [3:0]               wid;
   logic [DATA_WIDTH-1:0]    wdata;
   logic [STRB_WIDTH-1:0]    wstrb;
   logic                     wlast;

   logic                     bvalid;
   logic                     bready;
   logic [3:0]               bid;
   logic [1:0]               bresp;

   logic                     arvalid;
   logic                     arready;
   logic [3:0]               arid;
   logic [ADDRESS_WIDTH-1:0] araddr;
   logic [3:0]               arlen;
   logic [2:0]               arsize;
   logic [1:0]               arburst;

   logic                     rvalid;
   logic                     rready;
   logic [3:0]               rid;
   logic [DATA_WIDTH-1:0]    rdata;
   logic [1:0]               rresp;
   logic                     rlast;

   modport master (
      output awvalid, awid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready,
      output arvalid, arid, araddr, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rid, rdata, rresp, rlast,
      output rready
   );

   modport slave (
      input  awvalid, awid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready,
      input  arvalid, arid, araddr, arlen, arsize, arburst,
      output arready,
      output rvalid, rid, rdata, rresp, rlast,
      input  rready
   );
endinterface

// File: rtl/axi_mem_arbiter2.sv
// Two-master round-robin arbiter in front of one AXI-style memory slave.
// Write and read paths are arbitrated independently; a grant lives until B / last R handshake.
module axi_mem_arbiter2 #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32
) (
   input  logic               aclk,
   input  logic               arstn,
   axi_mem_arbiter2_if.slave  m0,
   axi_mem_arbiter2_if.slave  m1,
   axi_mem_arbiter2_if.master s,
   output logic [1:0]         wr_gnt,
   output logic [1:0]         rd_gnt,
   output logic               wr_len_err,
   output logic               rd_len_err
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH  = 5;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(16);

   typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

   wr_state_t              wr_state;
   rd_state_t              rd_state;
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic [CNT_WIDTH-1:0]   wr_cnt;
   logic [CNT_WIDTH-1:0]   rd_cnt;
   logic [3:0]             wr_len;
   logic [3:0]             rd_len;
   logic [1:0]             wr_req;
   logic [1:0]             rd_req;

   logic [ADDRESS_WIDTH-1:0] awaddr_sel;
   logic [ADDRESS_WIDTH-1:0] araddr_sel;
   logic [DATA_WIDTH-1:0]    wdata_sel;
   logic [STRB_WIDTH-1:0]    wstrb_sel;

   // ptr = 1 favours master 1 when both request; a lone requester always wins
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
      return (req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
   endfunction

   // A saturated counter means the last beat is at least the 17th, always wrong
   function automatic logic len_bad(input logic [CNT_WIDTH-1:0] c, input logic [3:0] len);
      return (c == CNT_MAX) || (cnt_inc(c) != ({1'b0, len} + CNT_WIDTH'(1)));
   endfunction

   assign wr_req = {m1.awvalid, m0.awvalid};
   assign rd_req = {m1.arvalid, m0.arvalid};

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         wr_state   <= WR_IDLE;
         wr_gnt     <= 2'b00;
         wr_ptr     <= 1'b0;
         wr_cnt     <= '0;
         wr_len     <= '0;
         wr_len_err <= 1'b0;
      end else begin
         wr_len_err <= 1'b0;
         case (wr_state)
            WR_IDLE: if (|wr_req) begin
               wr_gnt   <= rr_pick(wr_req, wr_ptr);
               wr_state <= WR_ADDR;
            end
            WR_ADDR: if (s.awvalid && s.awready) begin
               wr_len   <= s.awlen;
               wr_cnt   <= '0;
               wr_state <= WR_DATA;
            end
            WR_DATA: if (s.wvalid && s.wready) begin
               wr_cnt <= cnt_inc(wr_cnt);
               if (s.wlast) begin
                  wr_len_err <= len_bad(wr_cnt, wr_len);
                  wr_state   <= WR_RESP;
               end
            end
            WR_RESP: if (s.bvalid && s.bready) begin
               wr_gnt   <= 2'b00;
               wr_ptr   <= wr_gnt[0];
               wr_state <= WR_IDLE;
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         rd_state   <= RD_IDLE;
         rd_gnt     <= 2'b00;
         rd_ptr     <= 1'b0;
         rd_cnt     <= '0;
         rd_len     <= '0;
         rd_len_err <= 1'b0;
      end else begin
         rd_len_err <= 1'b0;
         case (rd_state)
            RD_IDLE: if (|rd_req) begin
               rd_gnt   <= rr_pick(rd_req, rd_ptr);
               rd_state <= RD_ADDR;
            end
            RD_ADDR: if (s.arvalid && s.arready) begin
               rd_len   <= s.arlen;
               rd_cnt   <= '0;
               rd_state <= RD_DATA;
            end
            RD_DATA: if (s.rvalid && s.rready) begin
               rd_cnt <= cnt_inc(rd_cnt);
               if (s.rlast) begin
                  rd_len_err <= len_bad(rd_cnt, rd_len);
                  rd_gnt     <= 2'b00;
                  rd_ptr     <= rd_gnt[0];
                  rd_state   <= RD_IDLE;
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   // Write path routing: handshakes gated by state and grant, payload by grant only
   assign awaddr_sel = wr_gnt[1] ? m1.awaddr : (wr_gnt[0] ? m0.awaddr : '0);
   assign wdata_sel  = wr_gnt[1] ? m1.wdata  : (wr_gnt[0] ? m0.wdata  : '0);
   assign wstrb_sel  = wr_gnt[1] ? m1.wstrb  : (wr_gnt[0] ? m0.wstrb  : '0);

   assign s.awvalid = (wr_state == WR_ADDR) && |(wr_gnt & {m1.awvalid, m0.awvalid});
   assign s.awid    = wr_gnt[1] ? m1.awid    : (wr_gnt[0] ? m0.awid    : '0);
   assign s.awaddr  = awaddr_sel;
   assign s.awlen   = wr_gnt[1] ? m1.awlen   : (wr_gnt[0] ? m0.awlen   : '0);
   assign s.awsize  = wr_gnt[1] ? m1.awsize  : (wr_gnt[0] ? m0.awsize  : '0);
   assign s.awburst = wr_gnt[1] ? m1.awburst : (wr_gnt[0] ? m0.awburst : '0);

   assign s.wvalid  = (wr_state == WR_DATA) && |(wr_gnt & {m1.wvalid, m0.wvalid});
   assign s.wid     = wr_gnt[1] ? m1.wid   : (wr_gnt[0] ? m0.wid   : '0);
   assign s.wdata   = wdata_sel;
   assign s.wstrb   = wstrb_sel;
   assign s.wlast   = wr_gnt[1] ? m1.wlast : (wr_gnt[0] ? m0.wlast : 1'b0);

   assign s.bready  = (wr_state == WR_RESP) && |(wr_gnt & {m1.bready, m0.bready});

   assign m0.awready = (wr_state == WR_ADDR) && wr_gnt[0] && s.awready;
   assign m1.awready = (wr_state == WR_ADDR) && wr_gnt[1] && s.awready;
   assign m0.wready  = (wr_state == WR_DATA) && wr_gnt[0] && s.wready;
   assign m1.wready  = (wr_state == WR_DATA) && wr_gnt[1] && s.wready;
   assign m0.bvalid  = (wr_state == WR_RESP) && wr_gnt[0] && s.bvalid;
   assign m1.bvalid  = (wr_state == WR_RESP) && wr_gnt[1] && s.bvalid;
   assign m0.bid     = wr_gnt[0] ? s.bid   : '0;
   assign m1.bid     = wr_gnt[1] ? s.bid   : '0;
   assign m0.bresp   = wr_gnt[0] ? s.bresp : '0;
   assign m1.bresp   = wr_gnt[1] ? s.bresp : '0;

   // Read path routing
   assign araddr_sel = rd_gnt[1] ? m1.araddr : (rd_gnt[0] ? m0.araddr : '0);

   assign s.arvalid = (rd_state == RD_ADDR) && |(rd_gnt & {m1.arvalid, m0.arvalid});
   assign s.arid    = rd_gnt[1] ? m1.arid    : (rd_gnt[0] ? m0.arid    : '0);
   assign s.araddr  = araddr_sel;
   assign s.arlen   = rd_gnt[1] ? m1.arlen   : (rd_gnt[0] ? m0.arlen   : '0);
   assign s.arsize  = rd_gnt[1] ? m1.arsize  : (rd_gnt[0] ? m0.arsize  : '0);
   assign s.arburst = rd_gnt[1] ? m1.arburst : (rd_gnt[0] ? m0.arburst : '0);

   assign s.rready  = (rd_state == RD_DATA) && |(rd_gnt & {m1.rready, m0.rready});

   assign m0.arready = (rd_state == RD_ADDR) && rd_gnt[0] && s.arready;
   assign m1.arready = (rd_state == RD_ADDR) && rd_gnt[1] && s.arready;
   assign m0.rvalid  = (rd_state == RD_DATA) && rd_gnt[0] && s.rvalid;
   assign m1.rvalid  = (rd_state == RD_DATA) && rd_gnt[1] && s.rvalid;
   assign m0.rid     = rd_gnt[0] ? s.rid   : '0;
   assign m1.rid     = rd_gnt[1] ? s.rid   : '0;
   assign m0.rdata   = rd_gnt[0] ? s.rdata : '0;
   assign m1.rdata   = rd_gnt[1] ? s.rdata : '0;
   assign m0.rresp   = rd_gnt[0] ? s.rresp : '0;
   assign m1.rresp   = rd_gnt[1] ? s.rresp : '0;
   assign m0.rlast   = rd_gnt[0] ? s.rlast : 1'b0;
   assign m1.rlast   = rd_gnt[1] ? s.rlast : 1'b0;
endmodule

// File: tb/tb_axi_mem_arbiter2.sv
// Directed bench for axi_mem_arbiter2: the bench plays both masters and the memory slave.
module tb_axi_mem_arbiter2;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   logic       aclk  = 1'b0;
   logic       arstn = 1'b0;
   logic [1:0] wr_gnt;
   logic [1:0] rd_gnt;
   logic       wr_len_err;
   logic       rd_len_err;
   int unsigned vec_cnt = 0;
   int unsigned err_cnt = 0;

   axi_mem_arbiter2_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) m0_if ();
   axi_mem_arbiter2_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) m1_if ();
   axi_mem_arbiter2_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) s_if ();

   axi_mem_arbiter2 #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .aclk       (aclk),
      .arstn      (arstn),
      .m0         (m0_if),
      .m1         (m1_if),
      .s          (s_if),
      .wr_gnt     (wr_gnt),
      .rd_gnt     (rd_gnt),
      .wr_len_err (wr_len_err),
      .rd_len_err (rd_len_err)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_aw(input int m, input logic v, input logic [3:0] id,
                         input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size);
      if (m == 0) begin
         m0_if.awvalid = v; m0_if.awid = id; m0_if.awaddr = addr;
         m0_if.awlen = len; m0_if.awsize = size; m0_if.awburst = 2'b01;
      end else begin
         m1_if.awvalid = v; m1_if.awid = id; m1_if.awaddr = addr;
         m1_if.awlen = len; m1_if.awsize = size; m1_if.awburst = 2'b01;
      end
   endtask

   task automatic set_w(input int m, input logic v, input logic [3:0] id,
                        input logic [31:0] data, input logic [3:0] strb, input logic last);
      if (m == 0) begin
         m0_if.wvalid = v; m0_if.wid = id; m0_if.wdata = data; m0_if.wstrb = strb; m0_if.wlast = last;
      end else begin
         m1_if.wvalid = v; m1_if.wid = id; m1_if.wdata = data; m1_if.wstrb = strb; m1_if.wlast = last;
      end
   endtask

   task automatic set_ar(input int m, input logic v, input logic [3:0] id,
                         input logic [31:0] addr, input logic [3:0] len);
      if (m == 0) begin
         m0_if.arvalid = v; m0_if.arid = id; m0_if.araddr = addr;
         m0_if.arlen = len; m0_if.arsize = 3'd2; m0_if.arburst = 2'b01;
      end else begin
         m1_if.arvalid = v; m1_if.arid = id; m1_if.araddr = addr;
         m1_if.arlen = len; m1_if.arsize = 3'd2; m1_if.arburst = 2'b01;
      end
   endtask

   task automatic set_bready(input int m, input logic v);
      if (m == 0) m0_if.bready = v; else m1_if.bready = v;
   endtask

   task automatic set_rready(input int m, input logic v);
      if (m == 0) m0_if.rready = v; else m1_if.rready = v;
   endtask

   task automatic clr_inputs();
      for (int m = 0; m < 2; m++) begin
         set_aw(m, 1'b0, 4'd0, 32'd0, 4'd0, 3'd0);
         set_w(m, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
         set_ar(m, 1'b0, 4'd0, 32'd0, 4'd0);
         set_bready(m, 1'b0);
         set_rready(m, 1'b0);
      end
      s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.arready = 1'b0;
      s_if.bvalid = 1'b0; s_if.bid = 4'd0; s_if.bresp = 2'd0;
      s_if.rvalid = 1'b0; s_if.rid = 4'd0; s_if.rdata = 32'd0; s_if.rresp = 2'd0; s_if.rlast = 1'b0;
   endtask

   // Full write burst from master m; expects m to win arbitration in the coming idle cycle
   task automatic wr_txn(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size, input logic [3:0] strb,
                         input logic [31:0] dbase, input int beats, input logic exp_err);
      logic [1:0] g;
      g = (m == 0) ? 2'b01 : 2'b10;
      set_aw(m, 1'b1, id, addr, len, size);
      step();
      #1;
      chk("wr_gnt", 64'(wr_gnt), 64'(g));
      chk("s_awvalid", 64'(s_if.awvalid), 64'd1);
      chk("s_awaddr", 64'(s_if.awaddr), 64'(addr));
      chk("s_awid", 64'(s_if.awid), 64'(id));
      chk("s_awlen", 64'(s_if.awlen), 64'(len));
      chk("s_awsize", 64'(s_if.awsize), 64'(size));
      s_if.awready = 1'b1;
      #1;
      chk("m_awready", 64'((m == 0) ? m0_if.awready : m1_if.awready), 64'd1);
      chk("other_awready", 64'((m == 0) ? m1_if.awready : m0_if.awready), 64'd0);
      step();
      s_if.awready = 1'b0;
      set_aw(m, 1'b0, 4'd0, 32'd0, 4'd0, 3'd0);
      for (int b = 0; b < beats; b++) begin
         set_w(m, 1'b1, id, dbase + 32'(b), strb, b == beats - 1);
         s_if.wready = 1'b1;
         #1;
         chk("s_wvalid", 64'(s_if.wvalid), 64'd1);
         chk("s_wdata", 64'(s_if.wdata), 64'(dbase + 32'(b)));
         chk("s_wstrb", 64'(s_if.wstrb), 64'(strb));
         chk("m_wready", 64'((m == 0) ? m0_if.wready : m1_if.wready), 64'd1);
         step();
      end
      set_w(m, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
      s_if.wready = 1'b0;
      #1;
      chk("wr_len_err_pulse", 64'(wr_len_err), 64'(exp_err));
      s_if.bvalid = 1'b1; s_if.bid = id; s_if.bresp = 2'b00;
      set_bready(m, 1'b1);
      #1;
      chk("m_bvalid", 64'((m == 0) ? m0_if.bvalid : m1_if.bvalid), 64'd1);
      chk("other_bvalid", 64'((m == 0) ? m1_if.bvalid : m0_if.bvalid), 64'd0);
      chk("m_bid", 64'((m == 0) ? m0_if.bid : m1_if.bid), 64'(id));
      chk("m_bresp", 64'((m == 0) ? m0_if.bresp : m1_if.bresp), 64'd0);
      chk("s_bready", 64'(s_if.bready), 64'd1);
      step();
      s_if.bvalid = 1'b0; s_if.bid = 4'd0;
      set_bready(m, 1'b0);
      #1;
      chk("wr_gnt_released", 64'(wr_gnt), 64'd0);
      chk("wr_len_err_clear", 64'(wr_len_err), 64'd0);
   endtask

   // Full read burst to master m, optionally stalling its rready before beat stall_at
   task automatic rd_txn(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input int beats, input logic exp_err,
                         input int stall_at, input int stall_n);
      logic [1:0] g;
      g = (m == 0) ? 2'b01 : 2'b10;
      set_ar(m, 1'b1, id, addr, len);
      step();
      #1;
      chk("rd_gnt", 64'(rd_gnt), 64'(g));
      chk("s_arvalid", 64'(s_if.arvalid), 64'd1);
      chk("s_araddr", 64'(s_if.araddr), 64'(addr));
      chk("s_arlen", 64'(s_if.arlen), 64'(len));
      s_if.arready = 1'b1;
      #1;
      chk("m_arready", 64'((m == 0) ? m0_if.arready : m1_if.arready), 64'd1);
      step();
      s_if.arready = 1'b0;
      set_ar(m, 1'b0, 4'd0, 32'd0, 4'd0);
      for (int b = 0; b < beats; b++) begin
         s_if.rvalid = 1'b1; s_if.rid = id; s_if.rresp = 2'b00;
         s_if.rdata = addr + 32'(b * 16); s_if.rlast = (b == beats - 1);
         if (b == stall_at) begin
            for (int k = 0; k < stall_n; k++) begin
               set_rready(m, 1'b0);
               #1;
               chk("stall_s_rready", 64'(s_if.rready), 64'd0);
               chk("stall_rd_gnt", 64'(rd_gnt), 64'(g));
               step();
            end
         end
         set_rready(m, 1'b1);
         #1;
         chk("m_rvalid", 64'((m == 0) ? m0_if.rvalid : m1_if.rvalid), 64'd1);
         chk("other_rvalid", 64'((m == 0) ? m1_if.rvalid : m0_if.rvalid), 64'd0);
         chk("m_rdata", 64'((m == 0) ? m0_if.rdata : m1_if.rdata), 64'(addr + 32'(b * 16)));
         chk("m_rid", 64'((m == 0) ? m0_if.rid : m1_if.rid), 64'(id));
         chk("m_rlast", 64'((m == 0) ? m0_if.rlast : m1_if.rlast), 64'(b == beats - 1));
         chk("s_rready", 64'(s_if.rready), 64'd1);
         step();
      end
      s_if.rvalid = 1'b0; s_if.rlast = 1'b0; s_if.rid = 4'd0; s_if.rdata = 32'd0;
      set_rready(m, 1'b0);
      #1;
      chk("rd_len_err_pulse", 64'(rd_len_err), 64'(exp_err));
      chk("rd_gnt_released", 64'(rd_gnt), 64'd0);
      step();
      #1;
      chk("rd_len_err_clear", 64'(rd_len_err), 64'd0);
   endtask

   initial begin
      clr_inputs();
      #3;
      chk("rst_wr_gnt", 64'(wr_gnt), 64'd0);
      chk("rst_rd_gnt", 64'(rd_gnt), 64'd0);
      chk("rst_s_awvalid", 64'(s_if.awvalid), 64'd0);
      chk("rst_s_arvalid", 64'(s_if.arvalid), 64'd0);
      chk("rst_errs", 64'({wr_len_err, rd_len_err}), 64'd0);
      step();
      step();
      arstn = 1'b1;
      step();

      // lone master 1, single beat
      wr_txn(1, 4'd5, 32'd22, 4'd0, 3'd1, 4'b0011, 32'h7092, 1, 1'b0);

      // simultaneous: master 0 first, then the waiting master 1
      set_aw(1, 1'b1, 4'd6, 32'h100, 4'd1, 3'd2);
      wr_txn(0, 4'd2, 32'h200, 4'd1, 3'd2, 4'hf, 32'hA000, 2, 1'b0);
      wr_txn(1, 4'd6, 32'h100, 4'd1, 3'd2, 4'hf, 32'hB000, 2, 1'b0);
      // third contention goes back to master 0
      set_aw(1, 1'b1, 4'd6, 32'h180, 4'd0, 3'd2);
      wr_txn(0, 4'd3, 32'h280, 4'd0, 3'd2, 4'hf, 32'hC000, 1, 1'b0);
      wr_txn(1, 4'd6, 32'h180, 4'd0, 3'd2, 4'hf, 32'hD000, 1, 1'b0);

      // concurrent read by master 0 and write by master 1
      fork
         rd_txn(0, 4'd3, 32'h1000, 4'd3, 4, 1'b0, -1, 0);
         wr_txn(1, 4'd7, 32'h300, 4'd1, 3'd2, 4'hf, 32'hE000, 2, 1'b0);
         begin
            step();
            #1;
            chk("concurrent_gnts", 64'({wr_gnt, rd_gnt}), 64'h9);
         end
      join
      step();

      // rready stall mid-burst
      rd_txn(0, 4'd4, 32'h2000, 4'd3, 4, 1'b0, 2, 3);
      // short write and short read
      wr_txn(0, 4'd8, 32'h400, 4'd2, 3'd2, 4'hf, 32'h1100, 2, 1'b1);
      rd_txn(1, 4'd9, 32'h3000, 4'd1, 3, 1'b1, -1, 0);
      // 16 beats is legal for awlen 15; 17 overflows the saturating counter
      wr_txn(0, 4'd1, 32'h500, 4'd15, 3'd2, 4'hf, 32'h2200, 16, 1'b0);
      wr_txn(1, 4'd2, 32'h600, 4'd15, 3'd2, 4'hf, 32'h3300, 17, 1'b1);
      // pointer now favours master 0; serve 0, then contention goes to master 1
      wr_txn(0, 4'd3, 32'h700, 4'd0, 3'd2, 4'hf, 32'h4400, 1, 1'b0);
      set_aw(0, 1'b1, 4'd4, 32'h780, 4'd0, 3'd2);
      wr_txn(1, 4'd5, 32'h800, 4'd0, 3'd2, 4'hf, 32'h5500, 1, 1'b0);
      wr_txn(0, 4'd4, 32'h780, 4'd0, 3'd2, 4'hf, 32'h6600, 1, 1'b0);

      // reset in WR_DATA while the pointer favours master 1
      set_aw(0, 1'b1, 4'd9, 32'h900, 4'd3, 3'd2);
      step();
      s_if.awready = 1'b1;
      step();
      s_if.awready = 1'b0;
      set_aw(0, 1'b0, 4'd0, 32'd0, 4'd0, 3'd0);
      set_w(0, 1'b1, 4'd9, 32'h7777, 4'hf, 1'b0);
      s_if.wready = 1'b1;
      #1;
      chk("pre_rst_s_wvalid", 64'(s_if.wvalid), 64'd1);
      arstn = 1'b0;
      #1;
      chk("rst_mid_wr_gnt", 64'(wr_gnt), 64'd0);
      chk("rst_mid_s_wvalid", 64'(s_if.wvalid), 64'd0);
      chk("rst_mid_m0_wready", 64'(m0_if.wready), 64'd0);
      chk("rst_mid_s_wdata", 64'(s_if.wdata), 64'd0);
      chk("rst_mid_s_awaddr", 64'(s_if.awaddr), 64'd0);
      clr_inputs();
      step();
      arstn = 1'b1;
      step();
      set_aw(1, 1'b1, 4'd10, 32'hA00, 4'd0, 3'd2);
      wr_txn(0, 4'd11, 32'hB00, 4'd0, 3'd2, 4'hf, 32'h8800, 1, 1'b0);
      wr_txn(1, 4'd10, 32'hA00, 4'd0, 3'd2, 4'hf, 32'h9900, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
